// File: rtl/data_store_tx_arbiter_if.sv
// Bundle of signals between two data_store_tx instances, the arbiter and the transmit path.
// The arbiter connects through the master modport; the stores/transmit side use slave.
interface data_store_tx_arbiter_if #(
    parameter int unsigned N = 2
) ();
    logic         a_axiiv;
    logic         b_axiiv;
    logic         a_axiov;
    logic [N-1:0] a_axiod;
    logic         b_axiov;
    logic [N-1:0] b_axiod;
    logic [15:0]  a_length;
    logic [15:0]  a_cksum;
    logic [15:0]  b_length;
    logic [15:0]  b_cksum;
    logic         a_read_request;
    logic         b_read_request;
    logic         axiov;
    logic [N-1:0] axiod;
    logic         sel;
    logic         busy;
    logic [15:0]  frame_length;
    logic [15:0]  frame_cksum;
    logic         frame_done;
    logic         timeout_err;

    modport master (
        input  a_axiiv, b_axiiv, a_axiov, a_axiod, b_axiov, b_axiod,
        input  a_length, a_cksum, b_length, b_cksum,
        output a_read_request, b_read_request, axiov, axiod, sel, busy,
        output frame_length, frame_cksum, frame_done, timeout_err
    );

    modport slave (
        output a_axiiv, b_axiiv, a_axiov, a_axiod, b_axiov, b_axiod,
        output a_length, a_cksum, b_length, b_cksum,
        input  a_read_request, b_read_request, axiov, axiod, sel, busy,
        input  frame_length, frame_cksum, frame_done, timeout_err
    );
endinterface

// File: rtl/data_store_tx_arbiter.sv
// Round-robin arbiter sharing one transmit stream between two data stores, with an
// inter-frame gap and an abort for a store that never answers its read request.
module data_store_tx_arbiter #(
    parameter int unsigned N       = 2,
    parameter int unsigned GAP     = 48,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                    clk,
    input logic                    rst,
    data_store_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {StIdle, StReq, StStream, StGap} state_e;

    state_e       state_q, state_d;
    logic         sel_q, sel_d;
    logic         last_sel_q, last_sel_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         a_prev_q, b_prev_q;
    logic         a_pend_q, a_pend_d;
    logic         b_pend_q, b_pend_d;
    logic         axiov_q, axiov_d;
    logic [N-1:0] axiod_q, axiod_d;
    logic [15:0]  frame_length_q, frame_length_d;
    logic [15:0]  frame_cksum_q, frame_cksum_d;
    logic         frame_done_q, frame_done_d;
    logic         timeout_err_q, timeout_err_d;

    logic         a_fall, b_fall;
    logic         a_clr, b_clr;
    logic         grant;
    logic         g_axiov;
    logic [N-1:0] g_axiod;
    logic [15:0]  g_length, g_cksum;

    assign a_fall   = a_prev_q & ~bus.a_axiiv;
    assign b_fall   = b_prev_q & ~bus.b_axiiv;
    assign g_axiov  = sel_q ? bus.b_axiov  : bus.a_axiov;
    assign g_axiod  = sel_q ? bus.b_axiod  : bus.a_axiod;
    assign g_length = sel_q ? bus.b_length : bus.a_length;
    assign g_cksum  = sel_q ? bus.b_cksum  : bus.a_cksum;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        last_sel_d     = last_sel_q;
        cnt_d          = cnt_q;
        axiov_d        = 1'b0;
        axiod_d        = '0;
        frame_length_d = frame_length_q;
        frame_cksum_d  = frame_cksum_q;
        frame_done_d   = 1'b0;
        timeout_err_d  = 1'b0;
        a_clr          = 1'b0;
        b_clr          = 1'b0;
        grant          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (a_pend_q && b_pend_q) begin
                    grant = ~last_sel_q;
                end else begin
                    grant = b_pend_q;
                end
                if (a_pend_q || b_pend_q) begin
                    sel_d      = grant;
                    last_sel_d = grant;
                    cnt_d      = '0;
                    a_clr      = ~grant;
                    b_clr      = grant;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (g_axiov) begin
                    axiov_d = 1'b1;
                    axiod_d = g_axiod;
                    state_d = StStream;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StStream: begin
                if (g_axiov) begin
                    axiov_d = 1'b1;
                    axiod_d = g_axiod;
                end else begin
                    // Length/checksum are final once the store stops streaming.
                    frame_length_d = g_length;
                    frame_cksum_d  = g_cksum;
                    frame_done_d   = 1'b1;
                    cnt_d          = '0;
                    state_d        = StGap;
                end
            end
            StGap: begin
                if (cnt_q == 16'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new load completing on the grant cycle must not be lost.
        a_pend_d = a_fall | (a_pend_q & ~a_clr);
        b_pend_d = b_fall | (b_pend_q & ~b_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            sel_q          <= 1'b0;
            last_sel_q     <= 1'b1;
            cnt_q          <= '0;
            a_prev_q       <= 1'b0;
            b_prev_q       <= 1'b0;
            a_pend_q       <= 1'b0;
            b_pend_q       <= 1'b0;
            axiov_q        <= 1'b0;
            axiod_q        <= '0;
            frame_length_q <= '0;
            frame_cksum_q  <= '0;
            frame_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            last_sel_q     <= last_sel_d;
            cnt_q          <= cnt_d;
            a_prev_q       <= bus.a_axiiv;
            b_prev_q       <= bus.b_axiiv;
            a_pend_q       <= a_pend_d;
            b_pend_q       <= b_pend_d;
            axiov_q        <= axiov_d;
            axiod_q        <= axiod_d;
            frame_length_q <= frame_length_d;
            frame_cksum_q  <= frame_cksum_d;
            frame_done_q   <= frame_done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    logic active;
    assign active = (state_q == StReq) || (state_q == StStream);

    assign bus.a_read_request = active & ~sel_q;
    assign bus.b_read_request = active & sel_q;
    assign bus.axiov          = axiov_q;
    assign bus.axiod          = axiod_q;
    assign bus.sel            = sel_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.frame_length   = frame_length_q;
    assign bus.frame_cksum    = frame_cksum_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_data_store_tx_arbiter.sv
// Directed bench for data_store_tx_arbiter: two model stores answer read requests
// with programmable beat counts; a monitor logs grants, beats and pulses per cycle.
module tb_data_store_tx_arbiter;
    localparam int unsigned N       = 4;
    localparam int unsigned GAP     = 12;
    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic rst;

    data_store_tx_arbiter_if #(.N(N)) bus ();

    data_store_tx_arbiter #(.N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int a_nbeats = 0, b_nbeats = 0;
    int a_base   = 0, b_base   = 0;
    int a_idx    = 0, b_idx    = 0;

    int           grants[$];
    logic [N-1:0] beats[$];
    int done_cnt = 0, to_cnt = 0, to_cyc = 0;
    int a_rise_cyc = 0, b_rise_cyc = 0, a_rr_fall_cyc = 0;
    int last_beat_a = 0, last_beat_b = 0, busy_fall_cyc = 0;
    int zero_viol = 0, overlap_viol = 0, sel_viol = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        logic a_p, b_p, busy_p;
        a_p = 1'b0; b_p = 1'b0; busy_p = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.a_read_request && !a_p) begin a_rise_cyc = cyc; grants.push_back(0); end
            if (!bus.a_read_request && a_p) a_rr_fall_cyc = cyc;
            if (bus.b_read_request && !b_p) begin b_rise_cyc = cyc; grants.push_back(1); end
            if (bus.frame_done) done_cnt++;
            if (bus.timeout_err) begin to_cnt++; to_cyc = cyc; end
            if (bus.axiov) begin
                beats.push_back(bus.axiod);
                if (bus.sel) last_beat_b = cyc;
                else last_beat_a = cyc;
            end else if (bus.axiod !== '0) begin
                zero_viol++;
            end
            if (bus.a_read_request && bus.b_read_request) overlap_viol++;
            if ((bus.a_read_request && bus.sel !== 1'b0) ||
                (bus.b_read_request && bus.sel !== 1'b1)) sel_viol++;
            if (!bus.busy && busy_p) busy_fall_cyc = cyc;
            a_p    = bus.a_read_request;
            b_p    = bus.b_read_request;
            busy_p = bus.busy;
        end
    end

    // Model stores: stream base, base+1, ... while read_request is held.
    initial begin : store_model
        bus.a_axiov = 1'b0; bus.a_axiod = '0;
        bus.b_axiov = 1'b0; bus.b_axiod = '0;
        forever begin
            @(negedge clk);
            if (bus.a_read_request && a_idx < a_nbeats) begin
                bus.a_axiov = 1'b1; bus.a_axiod = N'(a_base + a_idx); a_idx++;
            end else begin
                bus.a_axiov = 1'b0; bus.a_axiod = '0;
            end
            if (!bus.a_read_request) a_idx = 0;
            if (bus.b_read_request && b_idx < b_nbeats) begin
                bus.b_axiov = 1'b1; bus.b_axiod = N'(b_base + b_idx); b_idx++;
            end else begin
                bus.b_axiov = 1'b0; bus.b_axiod = '0;
            end
            if (!bus.b_read_request) b_idx = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic arm(input bit which, input int n, output int fall_cyc);
        if (which) bus.b_axiiv = 1'b1; else bus.a_axiiv = 1'b1;
        repeat (n) step();
        if (which) bus.b_axiiv = 1'b0; else bus.a_axiiv = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_done(input int ngrants, input int max, input string name);
        int k = 0;
        while (!(grants.size() >= ngrants && !bus.busy) && k < max) begin
            step();
            k++;
        end
        checks++;
        if (k >= max) begin
            errors++;
            $display("FAIL %s: wait expired with grants=%0d busy=%0b, required grants=%0d and idle",
                     name, grants.size(), bus.busy, ngrants);
        end
    endtask

    task automatic wait_rr(input bit which, input bit level, input int max, input string name);
        int k = 0;
        while (((which ? bus.b_read_request : bus.a_read_request) !== level) && k < max) begin
            step();
            k++;
        end
        checks++;
        if (k >= max) begin
            errors++;
            $display("FAIL %s: read_request never reached %0b", name, level);
        end
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        logic [N+31:0] dat;
        rst = 1'b1;
        repeat (3) step();
        ctl = {bus.axiov, bus.a_read_request, bus.b_read_request, bus.sel, bus.busy,
               bus.frame_done | bus.timeout_err};
        dat = {bus.axiod, bus.frame_length, bus.frame_cksum};
        checks++;
        if (ctl !== 6'b0) begin
            errors++; $display("FAIL reset_ctl: got %b, want 000000", ctl);
        end
        checks++;
        if (dat !== '0) begin
            errors++; $display("FAIL reset_data: got %h, want 0", dat);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_a();
        int g0 = grants.size(), d0 = done_cnt, b0 = beats.size(), fall;
        a_nbeats = 6; a_base = 1;
        arm(1'b0, 5, fall);
        wait_done(g0 + 1, 200, "single_a_done");
        checks++;
        if (a_rise_cyc - fall !== 2) begin
            errors++; $display("FAIL single_a_req_latency: got %0d, want 2", a_rise_cyc - fall);
        end
        checks++;
        if (beats.size() - b0 !== 6) begin
            errors++; $display("FAIL single_a_beats: got %0d, want 6", beats.size() - b0);
        end
        for (int i = 0; i < 6; i++) begin
            if (b0 + i < beats.size()) begin
                checks++;
                if (beats[b0 + i] !== N'(i + 1)) begin
                    errors++;
                    $display("FAIL single_a_data[%0d]: got %0d, want %0d", i, beats[b0 + i], i + 1);
                end
            end
        end
        checks++;
        if (bus.frame_length !== 16'd6 || bus.frame_cksum !== 16'd21) begin
            errors++;
            $display("FAIL single_a_frame: got len=%0d ck=%0d, want len=6 ck=21",
                     bus.frame_length, bus.frame_cksum);
        end
        checks++;
        if (done_cnt - d0 !== 1 || grants.size() !== g0 + 1 || grants[g0] !== 0) begin
            errors++;
            $display("FAIL single_a_grants: got done=%0d grants=%0d, want done=1 one A grant",
                     done_cnt - d0, grants.size() - g0);
        end
    endtask

    task automatic test_both_pending();
        int g0, d0;
        do_reset();
        g0 = grants.size(); d0 = done_cnt;
        a_nbeats = 6; a_base = 1; b_nbeats = 3; b_base = 8;
        bus.a_axiiv = 1'b1; bus.b_axiiv = 1'b1;
        repeat (3) step();
        bus.a_axiiv = 1'b0; bus.b_axiiv = 1'b0;
        wait_done(g0 + 2, 400, "both_done");
        checks++;
        if (grants.size() !== g0 + 2 || grants[g0] !== 0 || grants[g0 + 1] !== 1) begin
            errors++; $display("FAIL both_order: got %0d grants, want A then B", grants.size() - g0);
        end
        checks++;
        if (b_rise_cyc - last_beat_a !== int'(GAP + 2)) begin
            errors++;
            $display("FAIL both_spacing: got %0d, want %0d", b_rise_cyc - last_beat_a, GAP + 2);
        end
        checks++;
        if (bus.frame_length !== 16'd3 || bus.frame_cksum !== 16'd27 || bus.sel !== 1'b1) begin
            errors++;
            $display("FAIL both_frame_b: got len=%0d ck=%0d sel=%0b, want len=3 ck=27 sel=1",
                     bus.frame_length, bus.frame_cksum, bus.sel);
        end
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++; $display("FAIL both_done_cnt: got %0d, want 2", done_cnt - d0);
        end
    endtask

    task automatic test_round_robin();
        int g0 = grants.size(), d0 = done_cnt, f;
        int exp_order[4] = '{0, 1, 0, 1};
        a_nbeats = 3; b_nbeats = 6;
        bus.a_axiiv = 1'b1; bus.b_axiiv = 1'b1;
        repeat (2) step();
        bus.a_axiiv = 1'b0; bus.b_axiiv = 1'b0;
        wait_rr(1'b1, 1'b1, 200, "rr_b_grant");
        arm(1'b0, 2, f);
        wait_rr(1'b1, 1'b0, 100, "rr_b_end");
        arm(1'b1, 2, f);
        wait_done(g0 + 4, 600, "rr_done");
        for (int i = 0; i < 4; i++) begin
            if (g0 + i < grants.size()) begin
                checks++;
                if (grants[g0 + i] !== exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d, want %0d", i, grants[g0 + i], exp_order[i]);
                end
            end
        end
        checks++;
        if (done_cnt - d0 !== 4 || grants.size() !== g0 + 4) begin
            errors++;
            $display("FAIL rr_count: got done=%0d grants=%0d, want 4 and 4",
                     done_cnt - d0, grants.size() - g0);
        end
    endtask

    task automatic test_timeout();
        int g0 = grants.size(), d0 = done_cnt, t0 = to_cnt, f;
        logic [15:0] fl0 = bus.frame_length;
        a_nbeats = 0;
        arm(1'b0, 2, f);
        wait_done(g0 + 1, 300, "timeout_done");
        checks++;
        if (to_cnt - t0 !== 1) begin
            errors++; $display("FAIL timeout_pulses: got %0d, want 1", to_cnt - t0);
        end
        checks++;
        if (to_cyc - a_rise_cyc !== int'(TIMEOUT)) begin
            errors++;
            $display("FAIL timeout_latency: got %0d, want %0d", to_cyc - a_rise_cyc, TIMEOUT);
        end
        checks++;
        if (a_rr_fall_cyc !== to_cyc) begin
            errors++; $display("FAIL timeout_req_drop: got cycle %0d, want %0d", a_rr_fall_cyc, to_cyc);
        end
        checks++;
        if (bus.frame_length !== fl0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL timeout_frame: got len=%0d done=%0d, want len=%0d done=0",
                     bus.frame_length, done_cnt - d0, fl0);
        end
        checks++;
        if (busy_fall_cyc - to_cyc !== int'(GAP)) begin
            errors++; $display("FAIL timeout_gap: got %0d, want %0d", busy_fall_cyc - to_cyc, GAP);
        end
    endtask

    task automatic test_reset_mid();
        int g0 = grants.size(), d0 = done_cnt, b0 = beats.size(), f, k = 0;
        logic [4:0] st;
        a_nbeats = 6; a_base = 1;
        arm(1'b0, 2, f);
        wait_rr(1'b0, 1'b1, 50, "rst_mid_grant");
        arm(1'b1, 1, f);
        while (beats.size() - b0 < 3 && k < 50) begin
            step();
            k++;
        end
        rst = 1'b1;
        step();
        st = {bus.axiov, bus.a_read_request, bus.b_read_request, bus.busy, bus.frame_done};
        checks++;
        if (st !== 5'b0 || bus.axiod !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b axiod=%0d, want 00000 axiod=0", st, bus.axiod);
        end
        rst = 1'b0;
        repeat (GAP + 20) step();
        checks++;
        if (grants.size() !== g0 + 1 || done_cnt !== d0 || bus.frame_length !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_pending: got grants=%0d done=%0d len=%0d, want 1 0 0",
                     grants.size() - g0, done_cnt - d0, bus.frame_length);
        end
    endtask

    task automatic test_rearm_own();
        int g0 = grants.size(), d0 = done_cnt, f;
        a_nbeats = 6; a_base = 1;
        arm(1'b0, 2, f);
        wait_rr(1'b0, 1'b1, 50, "rearm_grant");
        arm(1'b0, 2, f);
        wait_done(g0 + 2, 400, "rearm_done");
        repeat (5) step();
        checks++;
        if (grants.size() !== g0 + 2 || grants[g0] !== 0 || grants[g0 + 1] !== 0 ||
            done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL rearm_own: got grants=%0d done=%0d, want two A grants and 2 frames",
                     grants.size() - g0, done_cnt - d0);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (zero_viol !== 0) begin
            errors++; $display("FAIL axiod_zero_when_invalid: got %0d violations, want 0", zero_viol);
        end
        checks++;
        if (overlap_viol !== 0 || sel_viol !== 0) begin
            errors++;
            $display("FAIL request_exclusive: got overlap=%0d sel=%0d, want 0 0", overlap_viol, sel_viol);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.a_axiiv  = 1'b0;  bus.b_axiiv  = 1'b0;
        bus.a_length = 16'd6; bus.a_cksum  = 16'd21;
        bus.b_length = 16'd3; bus.b_cksum  = 16'd27;
        test_reset();
        test_single_a();
        test_both_pending();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_rearm_own();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_store_tx_arbiter.md
Name: data_store_tx_arbiter

Overview:
- Sequences and shares one transmit output stream between two data_store_tx instances (store A, store B).
- Tracks when each store has finished loading and grants stores round-robin.
- For the granted store: drives its read_request, forwards its N-bit stream, and latches its length/checksum at end of frame.
- Enforces an inter-frame gap and aborts a store that never responds. Sits between the data stores and the Ethernet transmit path.

Parameters:
N, 2, stream width in bits (matches the data_store_tx N).
GAP, 48, idle cycles enforced after each frame or abort (96 bit-times at N=2).
TIMEOUT, 16, max cycles in REQ waiting for granted store axiov before abort; 1..65535.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
a_axiiv  in  1  store A load-valid (same signal driving store A axiiv)
b_axiiv  in  1  store B load-valid
a_axiov  in  1  store A output valid
a_axiod  in  N  store A output data
b_axiov  in  1  store B output valid
b_axiod  in  N  store B output data
a_length  in  16  store A data_length
a_cksum  in  16  store A data_cksum
b_length  in  16  store B data_length
b_cksum  in  16  store B data_cksum
a_read_request  out  1  read request to store A
b_read_request  out  1  read request to store B
axiov  out  1  forwarded stream valid
axiod  out  N  forwarded stream data
sel  out  1  current/last grant (0=A, 1=B)
busy  out  1  high in any state other than IDLE
frame_length  out  16  length latched at end of last completed frame
frame_cksum  out  16  checksum latched at end of last completed frame
frame_done  out  1  one-cycle pulse at end of frame
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset values: all outputs 0. Pending flags 0. last_sel=1, so A wins the first tie. State IDLE. Counters 0.
- Pending flags: x_pend sets on a registered falling edge of x_axiiv (prev=1, now=0).
- x_pend clears on the cycle the FSM enters REQ for store x. If set and clear occur in the same cycle, set wins.
- A falling edge on the granted store while it is in REQ/STREAM re-arms pending for a later grant.
- IDLE:
  - Both pending: grant !last_sel.
  - One pending: grant that store.
  - Neither pending: stay in IDLE.
  - On grant: sel<=granted, last_sel<=granted, next state REQ. Decision takes 1 cycle.
- REQ:
  - Granted x_read_request=1; the other store's read_request stays 0. Timeout counter increments each cycle.
  - Granted x_axiov=1: go STREAM. That beat is forwarded.
  - Counter reaches TIMEOUT with no axiov: drop read_request, timeout_err pulse, go GAP. frame_* unchanged.
- STREAM:
  - x_read_request held 1.
  - axiov<=x_axiov and axiod<=x_axiod: registered, exactly 1-cycle latency.
  - First cycle with x_axiov=0:
    - read_request<=0.
    - frame_length<=x_length, frame_cksum<=x_cksum, sampled that same cycle.
    - frame_done pulses on the same edge the output axiov falls.
    - Go GAP.
- Forwarded data: axiod is 0 whenever axiov=0. The non-granted store's axiov/axiod are ignored.
- GAP: count GAP cycles with no output (axiov=0), then return to IDLE. busy falls entering IDLE. Pending flags keep updating during GAP.
- Minimum frame-to-frame spacing: GAP+2 cycles from the last valid output beat to the next read_request rise.
- Reset mid-operation: rst returns all state to reset values at the next edge, including mid-stream.
  - read_request and axiov drop at that edge.
  - Pending is lost; the store must reload.
- Counters: 16-bit; no wrap occurs because TIMEOUT and GAP are ≤ 65535.

Test Plan:
- Single frame A, N=4:
  - Stimulus: pulse a_axiiv for 5 cycles; a model store then emits nibbles 1..6 after request.
  - Response: a_read_request rises 2 cycles after a_axiiv falls; axiod=1,2,3,4,5,6 each 1 cycle after the model; frame_length/frame_cksum equal the model values; one frame_done pulse; b_read_request stays 0.
- Both pending simultaneously after reset:
  - Response: A is served first, then B.
  - B's read_request rises exactly GAP+2 cycles after A's last valid output beat.
  - sel=0 during A's frame, sel=1 during B's.
- Round-robin fairness: A re-armed during B's frame and B re-armed after -> grant order A,B,A,B. No store is granted twice in a row while the other is pending.
- Timeout:
  - Stimulus: arm A; model never raises a_axiov; TIMEOUT=16.
  - Response: timeout_err pulses once, 16 cycles after a_read_request rises; a_read_request drops; frame_length unchanged; FSM returns to IDLE after GAP.
- Reset mid-stream: assert rst on the 3rd valid beat -> next edge: axiov=0, read_requests=0, busy=0, all pending cleared, frame_done never pulses.
- Re-arm during own stream: a_axiiv falls again while A is streaming -> after GAP, A is granted again with no other requester.
